// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Takes a WIDTH-bit word over a load handshake and sends it one bit per clk
// on so, framed by so_valid and so_last. Words can follow each other with no
// idle cycle between them.
//
// Load handshake (valid/ready): a word is transferred at a rising edge where
// load_valid && load_ready. load_ready depends only on registered state, never
// on load_valid. Once load_valid is raised, din must stay stable until that
// transfer edge. load_ready is high in IDLE and on the last bit of a word. It
// is low during the earlier bits of a word; load_valid and din are then
// ignored.
module piso_tx #(
    parameter int   WIDTH     = 4,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;

    // cnt counts the bits that remain after the one currently on so.
    assign last_bit = (state == SHIFT) && (cnt == '0);
    assign accept   = load_valid && load_ready;

    // Move the next bit toward the output end and fill the vacated bit with 0.
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    // Decode all outputs from registered state only.
    // busy mirrors the FSM state bit, so it doubles as the state debug view.
    assign load_ready = (state == IDLE) || last_bit;
    assign so_valid   = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign so_last    = last_bit;
    assign so         = (state == SHIFT)
                        ? ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0])
                        : IDLE_LVL;

    // Transmit FSM. clr overrides loading and shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (clr) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= din;
                        cnt   <= CW'(WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= shreg_shifted;
                        cnt   <= cnt - 1'b1;
                    end else if (load_valid) begin
                        // Loading on the last bit keeps the output gap-free.
                        shreg <= din;
                        cnt   <= CW'(WIDTH - 1);
                    end else begin
                        shreg <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
